// File: rtl/lcd_arbiter.sv
// Round-robin owner of the shared LCD bus for two engines.
// Start/finish handshake, watchdog abort and post-finish dwell.
module lcd_arbiter #(
  parameter int DWELL = 25000000,
  parameter int WDOG  = 50000000,
  parameter int CNT_W = 26
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req,
  output logic [1:0]  start,
  input  logic [1:0]  finish,
  input  logic [13:0] m0_bus,
  input  logic [13:0] m1_bus,
  output logic        lcd_rst,
  output logic [1:0]  lcd_cs,
  output logic        lcd_rw,
  output logic        lcd_di,
  output logic        lcd_e,
  output logic [7:0]  lcd_d,
  output logic [1:0]  grant,
  output logic        busy,
  output logic        timeout_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_RUN,
    S_DWELL
  } state_t;

  localparam logic [CNT_W-1:0] WDOG_END  = CNT_W'(WDOG - 1);
  localparam logic [CNT_W-1:0] DWELL_END = CNT_W'(DWELL - 1);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
  localparam logic [13:0]      IDLE_PINS = 14'h2000;

  state_t           state;
  state_t           state_n;
  logic [1:0]       grant_n;
  logic             last;
  logic             last_n;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_n;
  logic             terr_n;
  logic             fin_g;
  logic [13:0]      pins;

  assign fin_g = |(finish & grant);
  assign busy  = (state != S_IDLE);
  assign start = (state == S_START) ? grant : 2'b00;

  // Next-state, owner selection and shared counter control.
  always_comb begin
    state_n = state;
    grant_n = grant;
    last_n  = last;
    cnt_n   = cnt;
    terr_n  = timeout_err;
    unique case (state)
      S_IDLE: begin
        if (req != 2'b00) begin
          if (req == 2'b11)
            grant_n = last ? 2'b01 : 2'b10;
          else
            grant_n = req;
          cnt_n   = '0;
          state_n = S_START;
        end
      end
      S_START: begin
        state_n = S_RUN;
      end
      S_RUN: begin
        if (fin_g) begin
          cnt_n   = '0;
          state_n = S_DWELL;
        end else if (cnt == WDOG_END) begin
          terr_n  = 1'b1;
          cnt_n   = '0;
          state_n = S_DWELL;
        end else begin
          cnt_n = cnt + ONE;
        end
      end
      S_DWELL: begin
        if (cnt == DWELL_END) begin
          grant_n = 2'b00;
          last_n  = grant[1];
          cnt_n   = '0;
          state_n = S_IDLE;
        end else begin
          cnt_n = cnt + ONE;
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // State and bookkeeping registers; engine 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      grant       <= 2'b00;
      last        <= 1'b1;
      cnt         <= '0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_n;
      grant       <= grant_n;
      last        <= last_n;
      cnt         <= cnt_n;
      timeout_err <= terr_n;
    end
  end

  // Pin mux follows the owner combinationally, idle values otherwise.
  always_comb begin
    pins = IDLE_PINS;
    unique case (1'b1)
      grant[0]: pins = m0_bus;
      grant[1]: pins = m1_bus;
      default:  pins = IDLE_PINS;
    endcase
  end

  assign {lcd_rst, lcd_cs, lcd_rw, lcd_di, lcd_e, lcd_d} = pins;

endmodule
